// File: rtl/reg_wb_if.sv
// reg_wb_if: handshake and bus bundle for reg_wb_queue.
//   Execute side : in_valid/in_ready/in_addr/in_data
//   reg_file side: wb_hold, write/rd_addr/rd_in
//   Status       : count
//   Lookup       : rs_addr/rt_addr in, rs_/rt_fwd_vld/data out
// Modports:
//   slave  - the queue itself
//   master - whoever drives execute requests and lookups (execute stage / bench)
interface reg_wb_if #(
  parameter int REG_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int RD_AW     = 2,
  parameter int RS_AW     = 4,
  parameter int RT_AW     = 3
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [RD_AW-1:0]     in_addr;
  logic [REG_WIDTH-1:0] in_data;
  logic                 wb_hold;
  logic                 write;
  logic [RD_AW-1:0]     rd_addr;
  logic [REG_WIDTH-1:0] rd_in;
  logic [CNT_W-1:0]     count;
  logic [RS_AW-1:0]     rs_addr;
  logic [RT_AW-1:0]     rt_addr;
  logic                 rs_fwd_vld;
  logic [REG_WIDTH-1:0] rs_fwd_data;
  logic                 rt_fwd_vld;
  logic [REG_WIDTH-1:0] rt_fwd_data;

  modport slave (
    input  in_valid, in_addr, in_data, wb_hold, rs_addr, rt_addr,
    output in_ready, write, rd_addr, rd_in, count,
           rs_fwd_vld, rs_fwd_data, rt_fwd_vld, rt_fwd_data
  );

  modport master (
    output in_valid, in_addr, in_data, wb_hold, rs_addr, rt_addr,
    input  in_ready, write, rd_addr, rd_in, count,
           rs_fwd_vld, rs_fwd_data, rt_fwd_vld, rt_fwd_data
  );
endinterface

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: writeback request buffer in front of reg_file's write port.
// Accepts requests from execute, drains them in order one per cycle onto
// write/rd_addr/rd_in, stalling while wb_hold is high.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; discards all queued entries
//   bus    - reg_wb_if.slave (request handshake, reg_file write port,
//            occupancy count, rs/rt forwarding lookups)
// Build option:
//   REG_BYPASS_EN - when defined, rs/rt lookups are matched against all
//                   queued entries and the newest matching data is forwarded.
//                   When undefined, forwarding outputs are tied to zero.
module reg_wb_queue #(
  parameter int REG_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int RD_AW     = 2,
  parameter int RS_AW     = 4,
  parameter int RT_AW     = 3
) (
  input logic     clk,
  input logic     reset,
  reg_wb_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RD_AW-1:0]     r_mem_addr [DEPTH];
  logic [REG_WIDTH-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  // Push never looks at pop, so a full queue stalls execute even when draining.
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = ~w_empty & ~bus.wb_hold;

  assign bus.in_ready = ~w_full;
  assign bus.write    = w_pop;
  assign bus.rd_addr  = w_empty ? '0 : r_mem_addr[r_rd_ptr];
  assign bus.rd_in    = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign bus.count    = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage contents are don't-care after reset; validity comes from r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= bus.in_addr;
      r_mem_data[r_wr_ptr] <= bus.in_data;
    end
  end

`ifdef REG_BYPASS_EN
  logic                 w_rs_vld;
  logic [REG_WIDTH-1:0] w_rs_data;
  logic                 w_rt_vld;
  logic [REG_WIDTH-1:0] w_rt_data;
  logic [PTR_W-1:0]     w_idx;
  logic                 w_rs_inrange;
  logic                 w_rt_inrange;

  // Lookup addresses wider than the write address only hit when their
  // upper bits are zero (registers beyond the write port's reach).
  assign w_rs_inrange = ((bus.rs_addr >> RD_AW) == '0);
  assign w_rt_inrange = ((bus.rt_addr >> RD_AW) == '0);

  // Walk entries oldest to newest so a later match overrides an earlier one.
  always_comb begin
    w_rs_vld  = 1'b0;
    w_rs_data = '0;
    w_rt_vld  = 1'b0;
    w_rt_data = '0;
    w_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < r_count) begin
        if (w_rs_inrange && (bus.rs_addr[RD_AW-1:0] == r_mem_addr[w_idx])) begin
          w_rs_vld  = 1'b1;
          w_rs_data = r_mem_data[w_idx];
        end
        if (w_rt_inrange && (bus.rt_addr[RD_AW-1:0] == r_mem_addr[w_idx])) begin
          w_rt_vld  = 1'b1;
          w_rt_data = r_mem_data[w_idx];
        end
      end
    end
  end

  assign bus.rs_fwd_vld  = w_rs_vld;
  assign bus.rs_fwd_data = w_rs_data;
  assign bus.rt_fwd_vld  = w_rt_vld;
  assign bus.rt_fwd_data = w_rt_data;
`else
  assign bus.rs_fwd_vld  = 1'b0;
  assign bus.rs_fwd_data = '0;
  assign bus.rt_fwd_vld  = 1'b0;
  assign bus.rt_fwd_data = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
module tb_reg_wb_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  entry_t model[$];
  entry_t sb[$];

  reg_wb_if #(.REG_WIDTH(8), .DEPTH(4), .RD_AW(2), .RS_AW(4), .RT_AW(3)) bus ();

  reg_wb_queue #(.REG_WIDTH(8), .DEPTH(4), .RD_AW(2), .RS_AW(4), .RT_AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Newest queued entry for a lookup address; only registers 0..3 are writable.
  function automatic void fwd_ref(input int a, output logic v, output logic [7:0] d);
    v = 1'b0;
    d = 8'h00;
`ifdef REG_BYPASS_EN
    if (a < 4)
      foreach (model[i])
        if (int'(model[i].addr) == a) begin
          v = 1'b1;
          d = model[i].data;
        end
`endif
  endfunction

  // Reference model: decides take/pop from its own occupancy, checks the DUT
  // before the edge, updates on the edge.
  logic   n_take, n_pop;
  entry_t n_ent;
  always begin
    logic       ev;
    logic [7:0] ed;
    @(negedge clk);
    n_take = 1'b0;
    n_pop  = 1'b0;
    if (reset) begin
      model.delete();
      sb.delete();
      chk("rst_write", 32'(bus.write), 0);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_rd_addr", 32'(bus.rd_addr), 0);
      chk("rst_rd_in", 32'(bus.rd_in), 0);
      chk("rst_fwd", {bus.rs_fwd_vld, bus.rt_fwd_vld, bus.rs_fwd_data, bus.rt_fwd_data}, 0);
    end else begin
      n_take = bus.in_valid && (model.size() < DEPTH);
      n_pop  = (model.size() > 0) && !bus.wb_hold;
      n_ent  = '{addr: bus.in_addr, data: bus.in_data};
      chk("count", 32'(bus.count), 32'(model.size()));
      chk("in_ready", 32'(bus.in_ready), 32'(model.size() < DEPTH));
      chk("write", 32'(bus.write), 32'(n_pop));
      if (model.size() == 0) begin
        chk("idle_rd_addr", 32'(bus.rd_addr), 0);
        chk("idle_rd_in", 32'(bus.rd_in), 0);
      end else begin
        chk("head_addr", 32'(bus.rd_addr), 32'(model[0].addr));
        chk("head_data", 32'(bus.rd_in), 32'(model[0].data));
      end
      fwd_ref(int'(bus.rs_addr), ev, ed);
      chk("rs_fwd_vld", 32'(bus.rs_fwd_vld), 32'(ev));
      chk("rs_fwd_data", 32'(bus.rs_fwd_data), 32'(ed));
      fwd_ref(int'(bus.rt_addr), ev, ed);
      chk("rt_fwd_vld", 32'(bus.rt_fwd_vld), 32'(ev));
      chk("rt_fwd_data", 32'(bus.rt_fwd_data), 32'(ed));
    end
    @(posedge clk);
    if (!reset) begin
      if (n_pop) void'(model.pop_front());
      if (n_take) begin
        model.push_back(n_ent);
        sb.push_back(n_ent);
      end
    end
  end

  // Monitor: every write issued must be the oldest expected request.
  always @(negedge clk) begin
    entry_t e;
    if (!reset && bus.write) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(bus.write), 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.rd_addr), 32'(e.addr));
        chk("wr_data", 32'(bus.rd_in), 32'(e.data));
      end
    end
  end

  task automatic push(input logic [1:0] a, input logic [7:0] d);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL push_timeout: request %0h:%0h never accepted", a, d);
    end
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.wb_hold  = 1'b0;
    for (int k = 0; k < 50 && (model.size() != 0 || sb.size() != 0); k++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("drain_sb_empty", 32'(sb.size()), 0);
    chk("drain_count", 32'(bus.count), 0);
  endtask

  initial begin
    bit acc, pend;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.wb_hold  = 1'b0;
    bus.rs_addr  = '0;
    bus.rt_addr  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_write", 32'(bus.write), 0);
    chk("idle_count", 32'(bus.count), 0);

    // Reset while three entries are pending
    bus.wb_hold = 1'b1;
    push(2'd0, 8'h01); push(2'd1, 8'h02); push(2'd2, 8'h03);
    chk("pre_rst_count", 32'(bus.count), 3);
    bus.wb_hold = 1'b0;
    reset = 1'b1;
    #1 chk("async_rst_write", 32'(bus.write), 0);
    chk("async_rst_count", 32'(bus.count), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single request into an empty queue
    push(2'd1, 8'hFF);
    chk("lat_write", 32'(bus.write), 1);
    chk("lat_rd_addr", 32'(bus.rd_addr), 1);
    chk("lat_rd_in", 32'(bus.rd_in), 32'hFF);
    @(posedge clk);
    #1 chk("lat_count_after", 32'(bus.count), 0);

    // Fill while held, fifth request stalls until hold releases
    bus.wb_hold = 1'b1;
    push(2'd0, 8'h11); push(2'd1, 8'h22); push(2'd2, 8'h33); push(2'd3, 8'h44);
    chk("full_count", 32'(bus.count), 4);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_write", 32'(bus.write), 0);
    fork
      push(2'd1, 8'h55);
      begin
        repeat (3) @(posedge clk);
        #1 bus.wb_hold = 1'b0;
      end
    join
    drain();

    // Steady push+pop at occupancy 2
    bus.wb_hold = 1'b1;
    push(2'd3, 8'hA0); push(2'd2, 8'hA1);
    bus.wb_hold = 1'b0;
    for (int i = 0; i < 10; i++) push(2'(i), 8'hB0 + 8'(i));
    chk("stream_count", 32'(bus.count), 2);
    drain();

    // Forwarding: newest pending write to reg 2 wins
    bus.wb_hold = 1'b1;
    push(2'd2, 8'hAA); push(2'd2, 8'hBB);
    bus.rs_addr = 4'd2;
    bus.rt_addr = 3'd2;
    #1;
`ifdef REG_BYPASS_EN
    chk("byp_rs", {bus.rs_fwd_vld, bus.rs_fwd_data}, {1'b1, 8'hBB});
    chk("byp_rt", {bus.rt_fwd_vld, bus.rt_fwd_data}, {1'b1, 8'hBB});
`else
    chk("nobyp_rs", {bus.rs_fwd_vld, bus.rs_fwd_data}, 0);
    chk("nobyp_rt", {bus.rt_fwd_vld, bus.rt_fwd_data}, 0);
`endif
    bus.rs_addr = 4'd9;
    #1 chk("byp_rs_oor", {bus.rs_fwd_vld, bus.rs_fwd_data}, 0);
    @(posedge clk);
    #1;
    drain();

    // Randomized traffic; a refused request is held unchanged until taken
    pend = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_addr  = 2'($urandom_range(0, 3));
        bus.in_data  = 8'($urandom);
      end
      bus.wb_hold = ($urandom_range(0, 2) == 0);
      bus.rs_addr = 4'($urandom_range(0, 15));
      bus.rt_addr = 3'($urandom_range(0, 7));
      @(negedge clk);
      acc  = bus.in_valid && bus.in_ready;
      pend = bus.in_valid && !acc;
      @(posedge clk);
      #1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
